// File: rtl/pe_dot.sv
`timescale 1ns/1ps
// pe_dot: LANES-wide dot-product PE with vector accumulation over a 3-stage stallable pipeline.
// Define PE_SAT_EN to clamp the accumulator on overflow; the default build wraps modulo 2^WIDTH_ACC.
module pe_dot #(
   parameter int LANES     = 4,
   parameter int WIDTH_A   = 16,
   parameter int WIDTH_B   = 16,
   parameter int WIDTH_ACC = 40,
   parameter int SIGNED    = 0,
   parameter int CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     valid_in,
   input  logic                     first_in,
   input  logic                     last_in,
   input  logic [LANES*WIDTH_A-1:0] a,
   input  logic [LANES*WIDTH_B-1:0] b,
   output logic                     valid_out,
   output logic [WIDTH_ACC-1:0]     result,
   output logic [WIDTH_ACC-1:0]     acc,
   output logic [CNT_W-1:0]         beat_cnt,
   output logic                     ovf
);
   localparam int PW  = WIDTH_A + WIDTH_B;
   localparam bit SGN = (SIGNED != 0);

   // Operands are widened past the product width so one signed multiply serves both modes.
   function automatic logic [PW-1:0] lane_mul(input logic [WIDTH_A-1:0] x,
                                              input logic [WIDTH_B-1:0] y);
      logic signed [PW+1:0] xs, ys, p;
      xs = {{(PW+2-WIDTH_A){SGN & x[WIDTH_A-1]}}, x};
      ys = {{(PW+2-WIDTH_B){SGN & y[WIDTH_B-1]}}, y};
      p  = xs * ys;
      return p[PW-1:0];
   endfunction

   function automatic logic [WIDTH_ACC-1:0] ext_acc(input logic [PW-1:0] p);
      logic [WIDTH_ACC-1:0] r;
      r         = {WIDTH_ACC{SGN & p[PW-1]}};
      r[PW-1:0] = p;
      return r;
   endfunction

`ifdef PE_SAT_EN
   function automatic logic [WIDTH_ACC-1:0] sat_acc(input logic [WIDTH_ACC:0] t);
      logic [WIDTH_ACC-1:0] r;
      if (!SGN) begin
         r = '1;
      end else if (t[WIDTH_ACC]) begin
         r = '0;
         r[WIDTH_ACC-1] = 1'b1;
      end else begin
         r = '1;
         r[WIDTH_ACC-1] = 1'b0;
      end
      return r;
   endfunction
`endif

   logic [PW-1:0]        prod_p0 [LANES];
   logic                 vld_p0, first_p0, last_p0;
   logic [WIDTH_ACC-1:0] lane_sum, sum_p1;
   logic                 vld_p1, first_p1, last_p1;
   logic                 vld_p2, vec_ovf;
   logic [WIDTH_ACC-1:0] base, next_acc;
   logic [WIDTH_ACC:0]   tot;
   logic                 ovf_now, next_ovf;
   logic [CNT_W-1:0]     next_cnt;

   // S1 -> S2: lane products and flags; data carries no reset, the valids qualify it.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < LANES; i++)
            prod_p0[i] <= lane_mul(a[i*WIDTH_A +: WIDTH_A], b[i*WIDTH_B +: WIDTH_B]);
         first_p0 <= first_in;
         last_p0  <= last_in;
         sum_p1   <= lane_sum;
         first_p1 <= first_p0;
         last_p1  <= last_p0;
      end
   end

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LANES; i++)
         lane_sum = lane_sum + ext_acc(prod_p0[i]);
   end

   // S3: accumulate one bit wider than the accumulator to expose the true sum.
   always_comb begin
      base     = first_p1 ? '0 : acc;
      tot      = {SGN & base[WIDTH_ACC-1], base} + {SGN & sum_p1[WIDTH_ACC-1], sum_p1};
      ovf_now  = SGN ? (tot[WIDTH_ACC] ^ tot[WIDTH_ACC-1]) : tot[WIDTH_ACC];
      next_acc = tot[WIDTH_ACC-1:0];
`ifdef PE_SAT_EN
      if (ovf_now)
         next_acc = sat_acc(tot);
`endif
      next_ovf = (vec_ovf & ~first_p1) | ovf_now;
      next_cnt = first_p1 ? CNT_W'(1) : ((&beat_cnt) ? beat_cnt : beat_cnt + 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0   <= 1'b0;
         vld_p1   <= 1'b0;
         vld_p2   <= 1'b0;
         acc      <= '0;
         beat_cnt <= '0;
         vec_ovf  <= 1'b0;
         result   <= '0;
         ovf      <= 1'b0;
      end else if (en) begin
         vld_p0 <= valid_in;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1 & last_p1;
         if (vld_p1) begin
            acc      <= next_acc;
            beat_cnt <= next_cnt;
            vec_ovf  <= next_ovf;
            if (last_p1) begin
               result <= next_acc;
               ovf    <= next_ovf;
            end
         end
      end
   end

   // A pulse caught by a stall is held in vld_p2 and shown once en returns.
   assign valid_out = vld_p2 & en;

endmodule

// File: tb/tb_pe_dot.sv
`timescale 1ns/1ps
// tb_pe_dot: three pe_dot builds (unsigned 16/16/40, signed 16/16/40, unsigned 8/8/18) under
// shared control, checked against a per-vector arithmetic model through result queues.
module tb_pe_dot;
   logic        clk, rst_n, en, valid_in, first_in, last_in;
   logic [63:0] a0, b0;
   logic [31:0] a2, b2;
   logic        valid_out0, valid_out1, valid_out2;
   logic [39:0] result0, result1, acc0, acc1;
   logic [17:0] result2, acc2;
   logic [15:0] beat_cnt0, beat_cnt1, beat_cnt2;
   logic        ovf0, ovf1, ovf2;

   int total = 0;
   int bad   = 0;

   typedef struct {longint res; int cnt; bit ovf;} exp_t;
   exp_t   q0[$], q1[$], q2[$];
   longint m_acc[3];
   int     m_cnt[3];
   bit     m_ovf[3];
   logic [15:0] la[4], lb[4];

   pe_dot dut0 (.clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .first_in(first_in),
                .last_in(last_in), .a(a0), .b(b0), .valid_out(valid_out0), .result(result0),
                .acc(acc0), .beat_cnt(beat_cnt0), .ovf(ovf0));
   pe_dot #(.SIGNED(1)) dut1 (.clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in),
                .first_in(first_in), .last_in(last_in), .a(a0), .b(b0), .valid_out(valid_out1),
                .result(result1), .acc(acc1), .beat_cnt(beat_cnt1), .ovf(ovf1));
   pe_dot #(.WIDTH_A(8), .WIDTH_B(8), .WIDTH_ACC(18)) dut2 (.clk(clk), .rst_n(rst_n), .en(en),
                .valid_in(valid_in), .first_in(first_in), .last_in(last_in), .a(a2), .b(b2),
                .valid_out(valid_out2), .result(result2), .acc(acc2), .beat_cnt(beat_cnt2),
                .ovf(ovf2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   // Lane value as each build interprets the shared 16-bit stimulus.
   function automatic longint lval(input int d, input logic [15:0] x);
      if (d == 2) return longint'(x[7:0]);
      if (d == 1) return longint'($signed(x));
      return longint'(x);
   endfunction

   function automatic void model_beat(input bit f, input bit l);
      for (int d = 0; d < 3; d++) begin
         longint s, t, hi, lo, m;
         int     w;
         bit     sg;
         exp_t   e;
         w  = (d == 2) ? 18 : 40;
         sg = (d == 1);
         m  = (longint'(1) << w) - 1;
         hi = sg ? (longint'(1) << (w - 1)) - 1 : m;
         lo = sg ? -(longint'(1) << (w - 1)) : 0;
         s  = 0;
         for (int i = 0; i < 4; i++) s += lval(d, la[i]) * lval(d, lb[i]);
         if (f) begin
            m_acc[d] = s;
            m_cnt[d] = 1;
            m_ovf[d] = 1'b0;
         end else begin
            t = m_acc[d] + s;
            if (m_cnt[d] < 65535) m_cnt[d]++;
            if (t > hi || t < lo) begin
               m_ovf[d] = 1'b1;
`ifdef PE_SAT_EN
               t = (t > hi) ? hi : lo;
`else
               t = t & m;
               if (t > hi) t -= (longint'(1) << w);
`endif
            end
            m_acc[d] = t;
         end
         if (l) begin
            e.res = m_acc[d];
            e.cnt = m_cnt[d];
            e.ovf = m_ovf[d];
            case (d)
               0:       q0.push_back(e);
               1:       q1.push_back(e);
               default: q2.push_back(e);
            endcase
         end
      end
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 3; d++) begin
         m_acc[d] = 0;
         m_cnt[d] = 0;
         m_ovf[d] = 1'b0;
      end
   endfunction

   task automatic set_lanes(input int x0, x1, x2, x3, y0, y1, y2, y3);
      la[0] = 16'(x0); la[1] = 16'(x1); la[2] = 16'(x2); la[3] = 16'(x3);
      lb[0] = 16'(y0); lb[1] = 16'(y1); lb[2] = 16'(y2); lb[3] = 16'(y3);
   endtask

   // Called just after a falling edge; the beat is taken on the following rising edge.
   task automatic drive(input bit v, input bit f, input bit l, input bit e);
      valid_in = v;
      first_in = f;
      last_in  = l;
      en       = e;
      for (int i = 0; i < 4; i++) begin
         a0[i*16 +: 16] = la[i];
         b0[i*16 +: 16] = lb[i];
         a2[i*8 +: 8]   = la[i][7:0];
         b2[i*8 +: 8]   = lb[i][7:0];
      end
      if (v && e) model_beat(f, l);
   endtask

   task automatic mon(input int d, input bit vo, input longint res, input longint ac,
                      input int cnt, input bit ov);
      exp_t e;
      int   n;
      if (!vo) return;
      n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
      if (n == 0) begin
         total++;
         bad++;
         $display("FAIL spurious_valid_out_d%0d: got a pulse, required none", d);
         return;
      end
      case (d)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
      chk($sformatf("result_d%0d", d), res, e.res);
      chk($sformatf("acc_at_out_d%0d", d), ac, e.res);
      chk($sformatf("beat_cnt_d%0d", d), longint'(cnt), longint'(e.cnt));
      chk($sformatf("ovf_d%0d", d), longint'(ov), longint'(e.ovf));
   endtask

   always begin
      @(posedge clk);
      #1;
      mon(0, valid_out0, longint'(result0), longint'(acc0), int'(beat_cnt0), ovf0);
      mon(1, valid_out1, longint'($signed(result1)), longint'($signed(acc1)), int'(beat_cnt1), ovf1);
      mon(2, valid_out2, longint'(result2), longint'(acc2), int'(beat_cnt2), ovf2);
   end

   task automatic b2b(input bit stall);
      int mask;
      mask = 0;
      @(negedge clk);
      set_lanes(1, 2, 3, 4, 5, 6, 7, 8);
      drive(1, 1, 1, 1);
      fork
         for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (valid_out0) mask |= (1 << i);
         end
         begin
            @(negedge clk);
            set_lanes(1, 1, 1, 1, 1, 1, 1, 1);
            drive(1, 1, 1, 1);
            @(negedge clk); drive(0, 0, 0, !stall);
            @(negedge clk); drive(0, 0, 0, !stall);
            @(negedge clk); drive(0, 0, 0, 1);
         end
      join
      chk(stall ? "stall_pulse_cycles" : "b2b_pulse_cycles", longint'(mask),
          stall ? longint'('h30) : longint'('h0C));
   endtask

   initial begin
      rst_n = 1'b1; en = 1'b1; valid_in = 1'b0; first_in = 1'b0; last_in = 1'b0;
      a0 = '0; b0 = '0; a2 = '0; b2 = '0;
      set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid_out", longint'(valid_out0), 0);
      chk("rst_result", longint'(result0), 0);
      chk("rst_acc", longint'(acc0), 0);
      chk("rst_beat_cnt", longint'(beat_cnt0), 0);
      chk("rst_ovf", longint'(ovf0), 0);
      rst_n = 1'b1;

      // Single-beat vector and its latency.
      @(negedge clk);
      set_lanes(1, 2, 3, 4, 5, 6, 7, 8);
      drive(1, 1, 1, 1);
      @(posedge clk);
      @(negedge clk); drive(0, 0, 0, 1);
      @(posedge clk); #1;
      chk("lat_no_early_pulse", longint'(valid_out0), 0);
      @(posedge clk); #1;
      chk("lat_pulse_cycle3", longint'(valid_out0), 1);
      chk("single_result", longint'(result0), 70);
      chk("single_beat_cnt", longint'(beat_cnt0), 1);
      chk("single_ovf", longint'(ovf0), 0);

      // Three-beat vector.
      @(negedge clk); set_lanes(10, 3, 100, 0, 2, 5, 7, 0); drive(1, 1, 0, 1);
      @(negedge clk); set_lanes(1, 1, 1, 1, 1, 1, 1, 1);    drive(1, 0, 0, 1);
      @(negedge clk); set_lanes(1, 1, 1, 1, 2, 2, 2, 2);    drive(1, 0, 1, 1);
      @(negedge clk); drive(0, 0, 0, 1);
      repeat (5) @(negedge clk);
      chk("three_beat_result", longint'(result0), 747);
      chk("three_beat_cnt", longint'(beat_cnt0), 3);

      b2b(1'b0);
      b2b(1'b1);

      // Signed build.
      @(negedge clk); set_lanes(-3, 4, -5, 6, 7, -8, 9, 10); drive(1, 1, 1, 1);
      @(negedge clk); drive(0, 0, 0, 1);
      repeat (5) @(negedge clk);
      chk("signed_result", longint'($signed(result1)), -38);
      chk("signed_ovf", longint'(ovf1), 0);

      // Overflow on the narrow build.
      @(negedge clk); set_lanes(255, 255, 255, 255, 255, 255, 255, 255); drive(1, 1, 0, 1);
      @(negedge clk); drive(1, 0, 1, 1);
      @(negedge clk); drive(0, 0, 0, 1);
      repeat (5) @(negedge clk);
`ifdef PE_SAT_EN
      chk("ovf_result", longint'(result2), 262143);
`else
      chk("ovf_result", longint'(result2), 258056);
`endif
      chk("ovf_flag", longint'(ovf2), 1);

      // Reset in the middle of a vector.
      @(negedge clk); set_lanes(1, 2, 3, 4, 5, 6, 7, 8); drive(1, 1, 0, 1);
      @(negedge clk); drive(1, 0, 0, 1);
      @(negedge clk); drive(0, 0, 0, 1);
      repeat (4) @(negedge clk);
      chk("partial_acc", longint'(acc0), 140);
      chk("partial_cnt", longint'(beat_cnt0), 2);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_valid_out", longint'(valid_out0), 0);
      chk("midrst_result", longint'(result0), 0);
      chk("midrst_acc", longint'(acc0), 0);
      chk("midrst_beat_cnt", longint'(beat_cnt0), 0);
      chk("midrst_ovf", longint'(ovf2), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); drive(1, 1, 1, 1);
      @(negedge clk); drive(0, 0, 0, 1);
      repeat (5) @(negedge clk);
      chk("post_rst_result", longint'(result0), 70);
      chk("post_rst_cnt", longint'(beat_cnt0), 1);

      // Randomized traffic with stalls, bubbles and loose first/last framing.
      for (int c = 0; c < 3000; c++) begin
         int mode;
         @(negedge clk);
         mode = int'($urandom_range(0, 3));
         for (int i = 0; i < 4; i++) begin
            case (mode)
               0:       begin la[i] = 16'($urandom); lb[i] = 16'($urandom); end
               1:       begin la[i] = 16'hFFFF; lb[i] = 16'hFFFF; end
               2:       begin la[i] = 16'($urandom_range(0, 15)); lb[i] = 16'($urandom_range(0, 15)); end
               default: begin la[i] = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
                              lb[i] = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF; end
            endcase
         end
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 7) != 0);
      end
      @(negedge clk); drive(0, 0, 0, 1);
      repeat (10) @(negedge clk);
      chk("drain_q0", longint'(q0.size()), 0);
      chk("drain_q1", longint'(q1.size()), 0);
      chk("drain_q2", longint'(q2.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
